// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory channel controller.
// Channel state encoding plus an index-width helper used to size consumer pointers.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } chan_state_t;

    // Width of an index into n items; never zero so single-item configs still elaborate.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational find-first-from-pointer arbiter.
// Returns the first requester at or after start (wrapping) that is not excluded.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int IDX_BITS = 3
) (
    input  logic [N-1:0]        request,
    input  logic [IDX_BITS-1:0] start,
    input  logic [N-1:0]        exclude,
    output logic [IDX_BITS-1:0] grant,
    output logic                grant_valid
);

    logic [N-1:0] eligible;
    int           pos;

    assign eligible = request & ~exclude;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        pos         = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!grant_valid && eligible[pos[IDX_BITS-1:0]]) begin
                grant       = pos[IDX_BITS-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_channel_controller.sv
// Multiplexes dcache consumer read/write requests onto NUM_CHANNELS memory channels,
// one request per channel, with round-robin claiming so no consumer starves.
module mem_channel_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 8,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int CONS_IDX_BITS = idx_bits(NUM_CONSUMERS);

    chan_state_t                              state      [NUM_CHANNELS];
    chan_state_t                              next_state [NUM_CHANNELS];
    logic [CONS_IDX_BITS-1:0]                 owner      [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                 busy;
    logic [CONS_IDX_BITS-1:0]                 rr_ptr;
    logic [CONS_IDX_BITS-1:0]                 rr_next;
    logic [NUM_CONSUMERS-1:0]                 write_req;
    logic [NUM_CONSUMERS-1:0]                 pending;
    logic [NUM_CHANNELS-1:0]                  claim;
    logic [NUM_CHANNELS-1:0][CONS_IDX_BITS-1:0] grant;

    // With writes disabled a write-only consumer never becomes pending, so write outputs stay at reset.
    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign pending   = (consumer_read_valid | write_req) & ~busy;

    // Each channel excludes every consumer claimed by lower-indexed channels this cycle.
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
        logic [NUM_CONSUMERS-1:0] exclude;
        logic [NUM_CONSUMERS-1:0] taken;
        logic [CONS_IDX_BITS-1:0] grant_idx;
        logic                     grant_valid;
        logic                     claim_here;

        if (k == 0) begin : g_first
            assign exclude = '0;
        end else begin : g_next
            assign exclude = g_chan[k-1].taken;
        end

        rr_arbiter #(
            .N        (NUM_CONSUMERS),
            .IDX_BITS (CONS_IDX_BITS)
        ) u_arb (
            .request     (pending),
            .start       (rr_ptr),
            .exclude     (exclude),
            .grant       (grant_idx),
            .grant_valid (grant_valid)
        );

        assign claim_here = (state[k] == IDLE) && grant_valid;
        assign taken      = exclude | (claim_here ? (NUM_CONSUMERS'(1) << grant_idx) : '0);
        assign claim[k]   = claim_here;
        assign grant[k]   = grant_idx;
    end

    // The highest-indexed claiming channel took the last consumer in scan order.
    always_comb begin
        rr_next = rr_ptr;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (claim[k]) begin
                rr_next = (grant[k] == CONS_IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant[k] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            next_state[k] = state[k];
            case (state[k])
                IDLE:           if (claim[k]) next_state[k] = consumer_read_valid[grant[k]] ? READ_WAITING : WRITE_WAITING;
                READ_WAITING:   if (mem_read_ready[k]) next_state[k] = READ_RELAYING;
                WRITE_WAITING:  if (mem_write_ready[k]) next_state[k] = WRITE_RELAYING;
                READ_RELAYING:  if (!consumer_read_valid[owner[k]]) next_state[k] = IDLE;
                WRITE_RELAYING: if (!write_req[owner[k]]) next_state[k] = IDLE;
                default:        next_state[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                state[k] <= IDLE;
            end
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                state[k] <= next_state[k];
            end
        end
    end

    // The mem_* address/data registers double as the latched request, so later consumer-side changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy                 <= '0;
            rr_ptr               <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                owner[k] <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                case (state[k])
                    IDLE: begin
                        if (claim[k]) begin
                            owner[k]        <= grant[k];
                            busy[grant[k]]  <= 1'b1;
                            if (consumer_read_valid[grant[k]]) begin
                                mem_read_valid[k]   <= 1'b1;
                                mem_read_address[k] <= consumer_read_address[grant[k]];
                            end else begin
                                mem_write_valid[k]   <= 1'b1;
                                mem_write_address[k] <= consumer_write_address[grant[k]];
                                mem_write_data[k]    <= consumer_write_data[grant[k]];
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (mem_read_ready[k]) begin
                            mem_read_valid[k]              <= 1'b0;
                            consumer_read_data[owner[k]]   <= mem_read_data[k];
                            consumer_read_ready[owner[k]]  <= 1'b1;
                        end
                    end
                    WRITE_WAITING: begin
                        if (mem_write_ready[k]) begin
                            mem_write_valid[k]             <= 1'b0;
                            consumer_write_ready[owner[k]] <= 1'b1;
                        end
                    end
                    READ_RELAYING: begin
                        if (!consumer_read_valid[owner[k]]) begin
                            consumer_read_ready[owner[k]] <= 1'b0;
                            busy[owner[k]]                <= 1'b0;
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!write_req[owner[k]]) begin
                            consumer_write_ready[owner[k]] <= 1'b0;
                            busy[owner[k]]                 <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A consumer must keep its request up until it sees the matching ready.
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_check
        a_read_held: assert property (@(posedge clk) disable iff (reset)
            (state[k] == READ_WAITING) |-> consumer_read_valid[owner[k]]);
        a_write_held: assert property (@(posedge clk) disable iff (reset)
            (state[k] == WRITE_WAITING) |-> write_req[owner[k]]);
    end

endmodule

// File: tb/tb_mem_channel_controller.sv
// Directed bench for mem_channel_controller with two channels and a behavioural memory responder.
module tb_mem_channel_controller;

    localparam int NC  = 8;
    localparam int NCH = 2;

    logic                  clk;
    logic                  reset;
    logic [NC-1:0]         consumer_read_valid;
    logic [NC-1:0][7:0]    consumer_read_address;
    logic [NC-1:0]         consumer_read_ready;
    logic [NC-1:0][7:0]    consumer_read_data;
    logic [NC-1:0]         consumer_write_valid;
    logic [NC-1:0][7:0]    consumer_write_address;
    logic [NC-1:0][7:0]    consumer_write_data;
    logic [NC-1:0]         consumer_write_ready;
    logic [NCH-1:0]        mem_read_valid;
    logic [NCH-1:0][7:0]   mem_read_address;
    logic [NCH-1:0]        mem_read_ready;
    logic [NCH-1:0][7:0]   mem_read_data;
    logic [NCH-1:0]        mem_write_valid;
    logic [NCH-1:0][7:0]   mem_write_address;
    logic [NCH-1:0][7:0]   mem_write_data;
    logic [NCH-1:0]        mem_write_ready;

    logic [7:0] mem_model [256];
    int         rd_lat [NCH];
    int         wr_lat [NCH];
    int         rd_cnt [NCH];
    int         wr_cnt [NCH];

    int vector_count;
    int miscompare_count;

    mem_channel_controller #(
        .ADDR_BITS     (8),
        .DATA_BITS     (8),
        .NUM_CONSUMERS (NC),
        .NUM_CHANNELS  (NCH),
        .WRITE_ENABLE  (1)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int c, input logic rd, input logic [7:0] raddr,
                                 input logic wr, input logic [7:0] waddr, input logic [7:0] wdata);
        consumer_read_valid[c]    = rd;
        consumer_read_address[c]  = raddr;
        consumer_write_valid[c]   = wr;
        consumer_write_address[c] = waddr;
        consumer_write_data[c]    = wdata;
    endtask

    task automatic waitReady(input string tag, input int c, input bit is_write, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = is_write ? consumer_write_ready[c] : consumer_read_ready[c];
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    // Memory responder: ready pulses for one cycle once a request has been up for its latency.
    initial begin
        mem_read_ready  = '0;
        mem_read_data   = '0;
        mem_write_ready = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (reset) begin
                    mem_read_ready[k]  = 1'b0;
                    mem_write_ready[k] = 1'b0;
                    rd_cnt[k] = 0;
                    wr_cnt[k] = 0;
                end else begin
                    if (mem_read_ready[k]) begin
                        mem_read_ready[k] = 1'b0;
                        rd_cnt[k] = 0;
                    end else if (mem_read_valid[k]) begin
                        rd_cnt[k]++;
                        if (rd_cnt[k] >= rd_lat[k]) begin
                            mem_read_ready[k] = 1'b1;
                            mem_read_data[k]  = mem_model[mem_read_address[k]];
                        end
                    end
                    if (mem_write_ready[k]) begin
                        mem_write_ready[k] = 1'b0;
                        wr_cnt[k] = 0;
                    end else if (mem_write_valid[k]) begin
                        wr_cnt[k]++;
                        if (wr_cnt[k] >= wr_lat[k]) begin
                            mem_write_ready[k] = 1'b1;
                            mem_model[mem_write_address[k]] = mem_write_data[k];
                        end
                    end
                end
            end
        end
    end

    initial begin
        int seen_cycle [NC];
        int held;
        bit served1, served6;

        vector_count     = 0;
        miscompare_count = 0;
        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        for (int k = 0; k < NCH; k++) begin
            rd_lat[k] = 2;
            wr_lat[k] = 1;
            rd_cnt[k] = 0;
            wr_cnt[k] = 0;
        end

        repeat (2) @(negedge clk);
        checkOutput("rst_mem_read_valid",  32'(mem_read_valid), 32'h0);
        checkOutput("rst_mem_write_valid", 32'(mem_write_valid), 32'h0);
        checkOutput("rst_cons_read_ready", 32'(consumer_read_ready), 32'h0);
        checkOutput("rst_cons_write_ready", 32'(consumer_write_ready), 32'h0);
        checkOutput("rst_cons_read_data3", 32'(consumer_read_data[3]), 32'h0);
        reset = 1'b0;

        // Single read from consumer 3, two-cycle memory.
        @(negedge clk);
        mem_model[8'h42] = 8'hA5;
        mem_model[8'h43] = 8'h3C;
        applyStimulus(3, 1'b1, 8'h42, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("rd_claim_valid", 32'(mem_read_valid), 32'h1);
        checkOutput("rd_claim_addr", 32'(mem_read_address[0]), 32'h42);
        consumer_read_address[3] = 8'h99;
        @(negedge clk);
        checkOutput("rd_addr_latched", 32'(mem_read_address[0]), 32'h42);
        checkOutput("rd_ready_not_yet", 32'(consumer_read_ready), 32'h0);
        @(negedge clk);
        checkOutput("rd_ready", 32'(consumer_read_ready), 32'h08);
        checkOutput("rd_data", 32'(consumer_read_data[3]), 32'hA5);
        checkOutput("rd_mem_valid_drop", 32'(mem_read_valid), 32'h0);
        consumer_read_valid[3] = 1'b0;
        @(negedge clk);
        checkOutput("rd_ready_drop", 32'(consumer_read_ready), 32'h0);
        applyStimulus(3, 1'b1, 8'h43, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("rd_reclaim_valid", 32'(mem_read_valid), 32'h1);
        checkOutput("rd_reclaim_addr", 32'(mem_read_address[0]), 32'h43);
        waitReady("rd2_timeout", 3, 1'b0, 10);
        checkOutput("rd2_data", 32'(consumer_read_data[3]), 32'h3C);
        consumer_read_valid[3] = 1'b0;
        @(negedge clk);

        // Single write from consumer 0.
        applyStimulus(0, 1'b0, 8'h00, 1'b1, 8'h10, 8'h7E);
        @(negedge clk);
        checkOutput("wr_claim_valid", 32'(mem_write_valid), 32'h1);
        checkOutput("wr_claim_addr", 32'(mem_write_address[0]), 32'h10);
        checkOutput("wr_claim_data", 32'(mem_write_data[0]), 32'h7E);
        checkOutput("wr_no_read", 32'(mem_read_valid), 32'h0);
        waitReady("wr_timeout", 0, 1'b1, 10);
        checkOutput("wr_mem_content", 32'(mem_model[8'h10]), 32'h7E);
        consumer_write_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("wr_ready_drop", 32'(consumer_write_ready), 32'h0);

        // Read and write both valid on consumer 5: read first, write after release.
        mem_model[8'h20] = 8'h5A;
        applyStimulus(5, 1'b1, 8'h20, 1'b1, 8'h21, 8'h33);
        @(negedge clk);
        checkOutput("rw_read_first", 32'(mem_read_valid), 32'h1);
        checkOutput("rw_read_addr", 32'(mem_read_address[0]), 32'h20);
        checkOutput("rw_no_write_yet", 32'(mem_write_valid), 32'h0);
        waitReady("rw_rd_timeout", 5, 1'b0, 10);
        checkOutput("rw_read_data", 32'(consumer_read_data[5]), 32'h5A);
        consumer_read_valid[5] = 1'b0;
        @(negedge clk);
        checkOutput("rw_read_ready_drop", 32'(consumer_read_ready), 32'h0);
        checkOutput("rw_write_not_claimable", 32'(mem_write_valid), 32'h0);
        @(negedge clk);
        checkOutput("rw_write_claim", 32'(mem_write_valid), 32'h1);
        checkOutput("rw_write_addr", 32'(mem_write_address[0]), 32'h21);
        checkOutput("rw_write_data", 32'(mem_write_data[0]), 32'h33);
        waitReady("rw_wr_timeout", 5, 1'b1, 10);
        consumer_write_valid[5] = 1'b0;
        @(negedge clk);

        // Reset brings the pointer back to 0 before the overload run.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Overload: all 8 consumers read at once, served in pairs 0..7.
        for (int k = 0; k < NCH; k++) rd_lat[k] = 1;
        for (int c = 0; c < NC; c++) begin
            mem_model[8'h80 + c] = 8'hC0 + 8'(c);
            applyStimulus(c, 1'b1, 8'(8'h80 + c), 1'b0, 8'h00, 8'h00);
            seen_cycle[c] = -1;
        end
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (consumer_read_valid[c] && consumer_read_ready[c]) begin
                    seen_cycle[c] = cyc;
                    checkOutput($sformatf("ovl_data%0d", c), 32'(consumer_read_data[c]), 32'(8'hC0 + 8'(c)));
                    consumer_read_valid[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            checkOutput($sformatf("ovl_cycle%0d", c), 32'(seen_cycle[c]), 32'(2 + 3 * (c / 2)));
        end

        // Reset asserted while channel 0 waits on memory.
        rd_lat[0] = 10;
        mem_model[8'h30] = 8'h6D;
        applyStimulus(2, 1'b1, 8'h30, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("rstw_claim_valid", 32'(mem_read_valid), 32'h1);
        checkOutput("rstw_claim_addr", 32'(mem_read_address[0]), 32'h30);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstw_mem_read_valid", 32'(mem_read_valid), 32'h0);
        checkOutput("rstw_cons_read_ready", 32'(consumer_read_ready), 32'h0);
        checkOutput("rstw_mem_read_addr", 32'(mem_read_address[0]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rd_lat[0] = 2;
        reset = 1'b0;
        waitReady("rstw_retry_timeout", 2, 1'b0, 10);
        checkOutput("rstw_retry_data", 32'(consumer_read_data[2]), 32'h6D);
        consumer_read_valid[2] = 1'b0;
        @(negedge clk);

        // Channel 0 stalls 20 cycles on consumer 4 while channel 1 serves 6 then 1.
        rd_lat[0] = 20;
        rd_lat[1] = 1;
        mem_model[8'h50] = 8'h11;
        mem_model[8'h60] = 8'h66;
        mem_model[8'h14] = 8'h41;
        applyStimulus(4, 1'b1, 8'h50, 1'b0, 8'h00, 8'h00);
        applyStimulus(6, 1'b1, 8'h60, 1'b0, 8'h00, 8'h00);
        applyStimulus(1, 1'b1, 8'h14, 1'b0, 8'h00, 8'h00);
        held    = 0;
        served1 = 1'b0;
        served6 = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (consumer_read_ready[4]) break;
            if (mem_read_valid[0] && mem_read_address[0] == 8'h50) held++;
            if (consumer_read_valid[6] && consumer_read_ready[6]) begin
                checkOutput("stall_data6", 32'(consumer_read_data[6]), 32'h66);
                served6 = 1'b1;
                consumer_read_valid[6] = 1'b0;
            end
            if (consumer_read_valid[1] && consumer_read_ready[1]) begin
                checkOutput("stall_data1", 32'(consumer_read_data[1]), 32'h41);
                served1 = 1'b1;
                consumer_read_valid[1] = 1'b0;
            end
        end
        checkOutput("stall_ready4", 32'(consumer_read_ready[4]), 32'h1);
        checkOutput("stall_data4", 32'(consumer_read_data[4]), 32'h11);
        checkOutput("stall_held_cycles", 32'(held), 32'd20);
        checkOutput("stall_served6", 32'(served6), 32'h1);
        checkOutput("stall_served1", 32'(served1), 32'h1);
        consumer_read_valid[4] = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
